ibex_rf_writeback: RTL and testbench
====================================

IBEX_RF_WRITEBACK -- requirements
Module: ibex_rf_writeback

Interface
Parameters:
REQ-001 The block SHALL have parameter RV32E, default 0, meaning only registers x0-x15 are writable.
REQ-002 The block SHALL have parameter DataWidth, default 32, meaning the width of every data port.
Ports:
REQ-003 clk_int  input  1  clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 ex_we_i  input  1  execute-stage write request.
REQ-006 ex_waddr_i  input  5  execute destination register.
REQ-007 ex_wdata_i  input  DataWidth  execute result.
REQ-008 ex_ready_o  output  1  execute write accepted this cycle when high with ex_we_i.
REQ-009 lsu_req_i  input  1  load issued; destination captured.
REQ-010 lsu_waddr_i  input  5  load destination register.
REQ-011 lsu_rvalid_i  input  1  load response valid.
REQ-012 lsu_rdata_i  input  DataWidth  load response data.
REQ-013 lsu_err_i  input  1  load bus error, qualified by lsu_rvalid_i.
REQ-014 raddr_a_i, raddr_b_i  input  5 each  decode-stage read addresses for the hazard check.
REQ-015 hazard_o  output  1  stall decode: read address matches an unwritten destination.
REQ-016 load_pending_o  output  1  a load response is outstanding.
REQ-017 rf_we_o, rf_waddr_o, rf_wdata_o  output  1/5/DataWidth  register-file write port, all registered.

Function
REQ-018 Load tracker SHALL be a two-state FSM: IDLE -> WAIT on lsu_req_i; WAIT -> IDLE on lsu_rvalid_i; lsu_req_i in WAIT and lsu_rvalid_i in IDLE SHALL be ignored.
REQ-019 On IDLE -> WAIT the block SHALL capture lsu_waddr_i into pend_addr; load_pending_o SHALL equal (state == WAIT).
REQ-020 One-entry skid buffer (buf_valid, buf_addr, buf_data) SHALL hold an accepted EX write that loses arbitration.
REQ-021 ex_ready_o SHALL be !buf_valid && !(state == WAIT && ex_waddr_i == pend_addr && pend_addr != 0) (WAW block).
REQ-022 Write source priority per cycle: LSU response (rvalid in WAIT, no error) > buffer > newly accepted EX write.
REQ-023 The selected write SHALL appear on rf_we_o/rf_waddr_o/rf_wdata_o exactly one cycle after selection; rf_we_o SHALL be low in cycles with no selected write.
REQ-024 Accepted EX write that loses to LSU SHALL enter the buffer; buffer SHALL drain on the next cycle with no LSU write.
REQ-025 Buffer drain and new EX acceptance in the same cycle SHALL NOT occur (ex_ready_o low while buf_valid).
REQ-026 Writes to address 0, and with RV32E=1 addresses with bit 4 set, SHALL be dropped: accepted, never buffered, rf_we_o stays low.
REQ-027 Load response with lsu_err_i high SHALL return FSM to IDLE without a register write.
REQ-028 hazard_o SHALL be combinational: high if (state == WAIT, pend_addr != 0, raddr_a_i or raddr_b_i == pend_addr) or (buf_valid, buf_addr matches either read address) or (rf_we_o, rf_waddr_o matches either read address).
REQ-029 lsu_req_i and lsu_rvalid_i in the same cycle while IDLE SHALL capture the new load only; the response SHALL be ignored.

Reset
REQ-030 While rst_ni low: state = IDLE, pend_addr = 0, buf_valid = 0, rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0; hence hazard_o = 0, load_pending_o = 0, ex_ready_o = 1.
REQ-031 Reset asserted mid-load or with buffer full SHALL discard the outstanding load and buffered write; no write is issued after reset release.

Verification
REQ-032 EX write x5 = 0x0000_1234, idle -> next cycle rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 0x0000_1234.
REQ-033 Load to x7, then rvalid with 0xDEAD_BEEF same cycle as EX write x3 = 0x11 -> cycle+1 writes x7 = 0xDEAD_BEEF, cycle+2 writes x3 = 0x11; ex_ready_o low in cycle+1.
REQ-034 Load pending to x9; raddr_a_i = 9 -> hazard_o = 1; EX write to x9 -> ex_ready_o = 0 until the response is written.
REQ-035 Load to x4 with rvalid and lsu_err_i = 1 -> no rf_we_o pulse, load_pending_o falls, hazard on x4 clears.
REQ-036 EX write x0 = 0xFFFF_FFFF, and with RV32E=1 EX write x20 -> ex_ready_o = 1, rf_we_o stays 0.
REQ-037 Buffer full and load pending, assert rst_ni low for one cycle -> all outputs at reset values, no write after release.

Source files
------------

// File: rtl/ibex_rf_writeback.sv
// Register-file writeback arbiter.
// Merges execute-stage results and load responses onto a single
// registered register-file write port. It also tracks one outstanding load
// and raises a decode-stage hazard for any destination not yet written.
module ibex_rf_writeback #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_int,
    input  logic                 rst_ni,

    // Execute-stage write request
    input  logic                 ex_we_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,

    // Load/store unit
    input  logic                 lsu_req_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic                 lsu_rvalid_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    input  logic                 lsu_err_i,

    // Decode-stage hazard check
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 hazard_o,
    output logic                 load_pending_o,

    // Register-file write port
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o
);

    typedef enum logic {
        LdIdle = 1'b0,
        LdWait = 1'b1
    } ld_state_e;

    ld_state_e            state_q, state_d;
    logic [4:0]           pend_addr_q, pend_addr_d;

    logic                 buf_valid_q, buf_valid_d;
    logic [4:0]           buf_addr_q, buf_addr_d;
    logic [DataWidth-1:0] buf_data_q, buf_data_d;

    logic                 rf_we_q, rf_we_d;
    logic [4:0]           rf_waddr_q, rf_waddr_d;
    logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;

    logic                 load_waiting;
    logic                 waw_block;
    logic                 ex_accept;
    logic                 ex_wr_valid;
    logic                 lsu_wr_valid;
    logic                 pend_hit;
    logic                 buf_hit;
    logic                 rf_hit;

    // x0 is hardwired to zero; RV32E has no x16-x31.
    function automatic logic addr_writable(input logic [4:0] addr);
        return (addr != 5'd0) && !(RV32E && addr[4]);
    endfunction

    assign load_waiting = (state_q == LdWait);

    // An EX write to the register an outstanding load targets must wait, or
    // the older load data would overwrite the newer EX result.
    assign waw_block  = load_waiting && (ex_waddr_i == pend_addr_q) && (pend_addr_q != 5'd0);
    assign ex_ready_o = !buf_valid_q && !waw_block;

    assign ex_accept    = ex_we_i && ex_ready_o;
    assign ex_wr_valid  = ex_accept && addr_writable(ex_waddr_i);
    assign lsu_wr_valid = load_waiting && lsu_rvalid_i && !lsu_err_i && addr_writable(pend_addr_q);

    // Any destination still in flight blocks a read of that register.
    assign pend_hit = load_waiting && (pend_addr_q != 5'd0) &&
                      ((raddr_a_i == pend_addr_q) || (raddr_b_i == pend_addr_q));
    assign buf_hit  = buf_valid_q &&
                      ((raddr_a_i == buf_addr_q) || (raddr_b_i == buf_addr_q));
    assign rf_hit   = rf_we_q &&
                      ((raddr_a_i == rf_waddr_q) || (raddr_b_i == rf_waddr_q));

    assign hazard_o       = pend_hit || buf_hit || rf_hit;
    assign load_pending_o = load_waiting;

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

    // Load tracker next state: one outstanding load at a time. A request in
    // WAIT and a response in IDLE are both ignored.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block can leave a stale value and infer a latch.
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        case (state_q)
            LdIdle: begin
                if (lsu_req_i) begin
                    state_d     = LdWait;
                    pend_addr_d = lsu_waddr_i;
                end
            end
            LdWait: begin
                if (lsu_rvalid_i) begin
                    state_d = LdIdle;
                end
            end
            default: begin
                state_d = LdIdle;
            end
        endcase
    end

    // Write-port arbitration: load response, then skid buffer, then new EX write.
    always_comb begin
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;

        if (lsu_wr_valid) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pend_addr_q;
            rf_wdata_d = lsu_rdata_i;
            // An EX write accepted this cycle loses the port and is parked.
            // ex_ready_o is low while the buffer is full, so this cannot
            // overwrite a held entry.
            if (ex_wr_valid) begin
                buf_valid_d = 1'b1;
                buf_addr_d  = ex_waddr_i;
                buf_data_d  = ex_wdata_i;
            end
        end else if (buf_valid_q) begin
            rf_we_d     = 1'b1;
            rf_waddr_d  = buf_addr_q;
            rf_wdata_d  = buf_data_q;
            buf_valid_d = 1'b0;
        end else if (ex_wr_valid) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ex_waddr_i;
            rf_wdata_d = ex_wdata_i;
        end
    end

    // Load tracker state register.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= LdIdle;
            pend_addr_q <= 5'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples the pre-edge values of the others.
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Skid buffer and register-file write port registers.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= 5'd0;
            // NOTE: the buffer payload is reset along with its valid bit.
            // It is only a single entry, and the reset keeps it free of X
            // values in simulation.
            buf_data_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= 5'd0;
            rf_wdata_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_ibex_rf_writeback.sv
// Bench for ibex_rf_writeback. Two instances (RV32E=0 and RV32E=1) share one
// directed stimulus. A queue-based model predicts every output each cycle,
// and hand-computed literal checks pin the key scenarios.
module tb_ibex_rf_writeback;

    logic        clk_int = 1'b0;
    logic        rst_ni;
    logic        ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        lsu_req_i;
    logic [4:0]  lsu_waddr_i;
    logic        lsu_rvalid_i;
    logic [31:0] lsu_rdata_i;
    logic        lsu_err_i;
    logic [4:0]  raddr_a_i;
    logic [4:0]  raddr_b_i;

    logic [1:0]  ready_w;
    logic [1:0]  hazard_w;
    logic [1:0]  pend_w;
    logic [1:0]  we_w;
    logic [4:0]  waddr_w [2];
    logic [31:0] wdata_w [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk_int = ~clk_int;

    ibex_rf_writeback #(.RV32E(1'b0), .DataWidth(32)) u_dut (
        .clk_int       (clk_int),
        .rst_ni        (rst_ni),
        .ex_we_i       (ex_we_i),
        .ex_waddr_i    (ex_waddr_i),
        .ex_wdata_i    (ex_wdata_i),
        .ex_ready_o    (ready_w[0]),
        .lsu_req_i     (lsu_req_i),
        .lsu_waddr_i   (lsu_waddr_i),
        .lsu_rvalid_i  (lsu_rvalid_i),
        .lsu_rdata_i   (lsu_rdata_i),
        .lsu_err_i     (lsu_err_i),
        .raddr_a_i     (raddr_a_i),
        .raddr_b_i     (raddr_b_i),
        .hazard_o      (hazard_w[0]),
        .load_pending_o(pend_w[0]),
        .rf_we_o       (we_w[0]),
        .rf_waddr_o    (waddr_w[0]),
        .rf_wdata_o    (wdata_w[0])
    );

    ibex_rf_writeback #(.RV32E(1'b1), .DataWidth(32)) u_dut_e (
        .clk_int       (clk_int),
        .rst_ni        (rst_ni),
        .ex_we_i       (ex_we_i),
        .ex_waddr_i    (ex_waddr_i),
        .ex_wdata_i    (ex_wdata_i),
        .ex_ready_o    (ready_w[1]),
        .lsu_req_i     (lsu_req_i),
        .lsu_waddr_i   (lsu_waddr_i),
        .lsu_rvalid_i  (lsu_rvalid_i),
        .lsu_rdata_i   (lsu_rdata_i),
        .lsu_err_i     (lsu_err_i),
        .raddr_a_i     (raddr_a_i),
        .raddr_b_i     (raddr_b_i),
        .hazard_o      (hazard_w[1]),
        .load_pending_o(pend_w[1]),
        .rf_we_o       (we_w[1]),
        .rf_waddr_o    (waddr_w[1]),
        .rf_wdata_o    (wdata_w[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%h expected=0x%h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    bit          m_wait [2];
    logic [4:0]  m_pend [2];
    bit          m_bv   [2];
    wr_t         m_buf  [2];
    bit          m_ov   [2];
    wr_t         m_out  [2];

    function automatic bit writable(input logic [4:0] a, input bit e);
        return (a != 5'd0) && !(e && a[4]);
    endfunction

    task automatic model_cycle(input int k);
        bit         e;
        bit         exp_ready;
        bit         exp_haz;
        logic [4:0] dests [$];
        wr_t        q [$];
        e = (k == 1);
        if (!rst_ni) begin
            m_wait[k] = 1'b0;
            m_pend[k] = 5'd0;
            m_bv[k]   = 1'b0;
            m_buf[k]  = '0;
            m_ov[k]   = 1'b0;
            m_out[k]  = '0;
        end
        // Outputs implied by the current model state and inputs.
        exp_ready = !m_bv[k] && !(m_wait[k] && ex_waddr_i == m_pend[k] && m_pend[k] != 5'd0);
        if (m_wait[k] && m_pend[k] != 5'd0) dests.push_back(m_pend[k]);
        if (m_bv[k]) dests.push_back(m_buf[k].addr);
        if (m_ov[k]) dests.push_back(m_out[k].addr);
        exp_haz = 1'b0;
        foreach (dests[i]) if (dests[i] == raddr_a_i || dests[i] == raddr_b_i) exp_haz = 1'b1;

        check($sformatf("mdl_ready[%0d]", k),   32'(ready_w[k]),  32'(exp_ready));
        check($sformatf("mdl_hazard[%0d]", k),  32'(hazard_w[k]), 32'(exp_haz));
        check($sformatf("mdl_pending[%0d]", k), 32'(pend_w[k]),   32'(m_wait[k]));
        check($sformatf("mdl_we[%0d]", k),      32'(we_w[k]),     32'(m_ov[k]));
        if (m_ov[k] || !rst_ni) begin
            check($sformatf("mdl_waddr[%0d]", k), 32'(waddr_w[k]), 32'(m_out[k].addr));
            check($sformatf("mdl_wdata[%0d]", k), wdata_w[k],      m_out[k].data);
        end
        if (!rst_ni) return;

        // Writes competing this cycle in priority order; the first takes
        // the port, whatever remains is held for later.
        if (m_wait[k] && lsu_rvalid_i && !lsu_err_i && writable(m_pend[k], e))
            q.push_back('{addr: m_pend[k], data: lsu_rdata_i});
        if (m_bv[k]) q.push_back(m_buf[k]);
        if (ex_we_i && exp_ready && writable(ex_waddr_i, e))
            q.push_back('{addr: ex_waddr_i, data: ex_wdata_i});
        m_ov[k] = (q.size() > 0);
        if (m_ov[k]) m_out[k] = q.pop_front();
        m_bv[k] = (q.size() > 0);
        if (m_bv[k]) m_buf[k] = q.pop_front();

        if (!m_wait[k] && lsu_req_i) begin
            m_wait[k] = 1'b1;
            m_pend[k] = lsu_waddr_i;
        end else if (m_wait[k] && lsu_rvalid_i) begin
            m_wait[k] = 1'b0;
        end
    endtask

    // Compare process: inputs change at the falling edge, outputs are
    // checked 2 time units later, well before the next rising edge.
    always @(negedge clk_int) begin
        #2;
        for (int k = 0; k < 2; k++) model_cycle(k);
    end

    // ---------------- stimulus ----------------
    task automatic defaults();
        rst_ni       = 1'b1;
        ex_we_i      = 1'b0;
        ex_waddr_i   = 5'd0;
        ex_wdata_i   = 32'h0;
        lsu_req_i    = 1'b0;
        lsu_waddr_i  = 5'd0;
        lsu_rvalid_i = 1'b0;
        lsu_rdata_i  = 32'h0;
        lsu_err_i    = 1'b0;
        raddr_a_i    = 5'd0;
        raddr_b_i    = 5'd0;
    endtask

    task automatic nc();
        @(negedge clk_int);
        defaults();
    endtask

    task automatic ex_wr(input logic [4:0] a, input logic [31:0] d);
        ex_we_i    = 1'b1;
        ex_waddr_i = a;
        ex_wdata_i = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_ready[%0d]", tag, k), 32'(ready_w[k]),  32'd1);
            check($sformatf("%s_hazard[%0d]", tag, k), 32'(hazard_w[k]), 32'd0);
            check($sformatf("%s_pend[%0d]", tag, k),  32'(pend_w[k]),   32'd0);
            check($sformatf("%s_we[%0d]", tag, k),    32'(we_w[k]),     32'd0);
            check($sformatf("%s_waddr[%0d]", tag, k), 32'(waddr_w[k]),  32'd0);
            check($sformatf("%s_wdata[%0d]", tag, k), wdata_w[k],       32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        defaults();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_int);
        #3 check_reset_outputs("rst");
        nc();

        // Plain EX write, visible one cycle later.
        nc(); ex_wr(5'd5, 32'h0000_1234);
        #3 check("x5_ready", 32'(ready_w[0]), 32'd1);
        nc();
        #3 check("x5_we", 32'(we_w[0]), 32'd1);
        check("x5_waddr", 32'(waddr_w[0]), 32'd5);
        check("x5_wdata", wdata_w[0], 32'h0000_1234);

        // Load to x7; its response collides with EX write x3.
        nc(); lsu_req_i = 1'b1; lsu_waddr_i = 5'd7;
        nc();
        #3 check("ld7_pending", 32'(pend_w[0]), 32'd1);
        nc(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hDEAD_BEEF; ex_wr(5'd3, 32'h11);
        #3 check("coll_ready", 32'(ready_w[0]), 32'd1);
        nc(); raddr_a_i = 5'd3;
        #3 check("coll_we1", 32'(we_w[0]), 32'd1);
        check("coll_waddr1", 32'(waddr_w[0]), 32'd7);
        check("coll_wdata1", wdata_w[0], 32'hDEAD_BEEF);
        check("coll_ready1", 32'(ready_w[0]), 32'd0);
        check("coll_buf_hazard", 32'(hazard_w[0]), 32'd1);
        nc();
        #3 check("coll_we2", 32'(we_w[0]), 32'd1);
        check("coll_waddr2", 32'(waddr_w[0]), 32'd3);
        check("coll_wdata2", wdata_w[0], 32'h11);

        // WAW block on x9 while its load is outstanding.
        nc(); lsu_req_i = 1'b1; lsu_waddr_i = 5'd9;
        nc(); raddr_a_i = 5'd9; ex_wr(5'd9, 32'h99);
        #3 check("x9_hazard", 32'(hazard_w[0]), 32'd1);
        check("x9_ready_a", 32'(ready_w[0]), 32'd0);
        nc(); raddr_a_i = 5'd9; ex_wr(5'd9, 32'h99);
        #3 check("x9_ready_b", 32'(ready_w[0]), 32'd0);
        nc(); ex_wr(5'd9, 32'h99); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h9000;
        #3 check("x9_ready_resp", 32'(ready_w[0]), 32'd0);
        nc(); ex_wr(5'd9, 32'h99);
        #3 check("x9_ready_after", 32'(ready_w[0]), 32'd1);
        check("x9_ld_wdata", wdata_w[0], 32'h9000);
        nc();
        #3 check("x9_ex_we", 32'(we_w[0]), 32'd1);
        check("x9_ex_wdata", wdata_w[0], 32'h99);

        // Load to x4 completing with a bus error.
        nc(); lsu_req_i = 1'b1; lsu_waddr_i = 5'd4;
        nc(); raddr_b_i = 5'd4;
        #3 check("x4_hazard", 32'(hazard_w[0]), 32'd1);
        nc(); raddr_b_i = 5'd4; lsu_rvalid_i = 1'b1; lsu_err_i = 1'b1; lsu_rdata_i = 32'hBAD;
        nc(); raddr_b_i = 5'd4;
        #3 check("x4_err_we", 32'(we_w[0]), 32'd0);
        check("x4_err_pending", 32'(pend_w[0]), 32'd0);
        check("x4_err_hazard", 32'(hazard_w[0]), 32'd0);

        // Dropped writes: x0 on both, x20 only on the RV32E instance.
        nc(); ex_wr(5'd0, 32'hFFFF_FFFF);
        #3 check("x0_ready", 32'(ready_w[0]), 32'd1);
        nc(); ex_wr(5'd20, 32'hABCD);
        #3 check("x0_we", 32'(we_w[0]), 32'd0);
        check("x20e_ready", 32'(ready_w[1]), 32'd1);
        nc();
        #3 check("x20_we", 32'(we_w[0]), 32'd1);
        check("x20_waddr", 32'(waddr_w[0]), 32'd20);
        check("x20e_we", 32'(we_w[1]), 32'd0);

        // Request and stray response together in IDLE: only the request counts.
        nc(); lsu_req_i = 1'b1; lsu_waddr_i = 5'd6; lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h5555;
        nc();
        #3 check("x6_pending", 32'(pend_w[0]), 32'd1);
        check("x6_stray_we", 32'(we_w[0]), 32'd0);
        nc(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h6666;
        nc();
        #3 check("x6_wdata", wdata_w[0], 32'h6666);
        check("x6_pending_end", 32'(pend_w[0]), 32'd0);

        // Reset with the buffer full and a new load being issued.
        nc(); lsu_req_i = 1'b1; lsu_waddr_i = 5'd12;
        nc();
        nc(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hC12; ex_wr(5'd13, 32'hD13);
        nc(); rst_ni = 1'b0; lsu_req_i = 1'b1; lsu_waddr_i = 5'd14;
        #3 check_reset_outputs("midrst");
        nc(); raddr_a_i = 5'd13;
        #3 check("post_rst_we", 32'(we_w[0]), 32'd0);
        check("post_rst_hazard", 32'(hazard_w[0]), 32'd0);
        check("post_rst_pending", 32'(pend_w[0]), 32'd0);
        nc();
        #3 check("post_rst_we2", 32'(we_w[0]), 32'd0);

        // Reset while a load is outstanding; its late response is ignored.
        nc(); lsu_req_i = 1'b1; lsu_waddr_i = 5'd15;
        nc(); rst_ni = 1'b0;
        #3 check("ldrst_pending", 32'(pend_w[0]), 32'd0);
        nc(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hF15; raddr_a_i = 5'd15;
        #3 check("ldrst_hazard", 32'(hazard_w[0]), 32'd0);
        nc();
        #3 check("ldrst_we", 32'(we_w[0]), 32'd0);

        repeat (2) nc();
        @(negedge clk_int);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
